// File: rtl/pool_sequencer.sv
// Sequential max-pooling engine: walks each pooling tile through a 1-cycle read port and writes one max per tile.
// Build option POOL_SIGNED_EN: two's-complement compare, tile max starts at the signed minimum.
module pool_sequencer #(
  parameter int NUM_FEATURES           = 10,
  parameter int CONVOLUTION_HEIGHT     = 10,
  parameter int CONVOLUTION_WIDTH      = 10,
  parameter int POOLING_STRIDE         = 2,
  parameter int CONVOLUTION_DATA_WIDTH = 8,
  parameter int POOLED_HEIGHT          = (CONVOLUTION_HEIGHT + POOLING_STRIDE - 1) / POOLING_STRIDE,
  parameter int POOLED_WIDTH           = (CONVOLUTION_WIDTH + POOLING_STRIDE - 1) / POOLING_STRIDE,
  localparam int FW  = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1,
  localparam int RW  = (CONVOLUTION_HEIGHT > 1) ? $clog2(CONVOLUTION_HEIGHT) : 1,
  localparam int CW  = (CONVOLUTION_WIDTH > 1) ? $clog2(CONVOLUTION_WIDTH) : 1,
  localparam int PRW = (POOLED_HEIGHT > 1) ? $clog2(POOLED_HEIGHT) : 1,
  localparam int PCW = (POOLED_WIDTH > 1) ? $clog2(POOLED_WIDTH) : 1,
  localparam int DW  = CONVOLUTION_DATA_WIDTH
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           pool_start,
  output logic           pool_busy,
  output logic           pool_done,
  output logic           rd_en,
  output logic [FW-1:0]  rd_feature,
  output logic [RW-1:0]  rd_row,
  output logic [CW-1:0]  rd_col,
  input  logic [DW-1:0]  rd_data,
  output logic           wr_valid,
  input  logic           wr_ready,
  output logic [FW-1:0]  wr_feature,
  output logic [PRW-1:0] wr_row,
  output logic [PCW-1:0] wr_col,
  output logic [DW-1:0]  wr_data
);

  localparam int TW = (POOLING_STRIDE > 1) ? $clog2(POOLING_STRIDE) : 1;
  localparam logic [FW-1:0]  F_LAST  = FW'(NUM_FEATURES - 1);
  localparam logic [PRW-1:0] PR_LAST = PRW'(POOLED_HEIGHT - 1);
  localparam logic [PCW-1:0] PC_LAST = PCW'(POOLED_WIDTH - 1);
`ifdef POOL_SIGNED_EN
  localparam logic [DW-1:0] MAX_INIT = {1'b1, {(DW-1){1'b0}}};
`else
  localparam logic [DW-1:0] MAX_INIT = '0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t           state_q;
  logic [FW-1:0]    feat_q;
  logic [PRW-1:0]   prow_q;
  logic [PCW-1:0]   pcol_q;
  logic [TW-1:0]    trow_q, tcol_q;
  logic [DW-1:0]    max_q;
  logic             rd_vld_q;
  logic             busy_q, done_q, rd_en_q, wr_valid_q;
  logic [FW-1:0]    rd_feature_q, wr_feature_q;
  logic [RW-1:0]    rd_row_q;
  logic [CW-1:0]    rd_col_q;
  logic [PRW-1:0]   wr_row_q;
  logic [PCW-1:0]   wr_col_q;
  logic [DW-1:0]    wr_data_q;

  logic [31:0]      tile_r0, tile_c0, tile_h, tile_w, next_r0, next_c0;
  logic             col_wrap, row_end, last_elem;
  logic             pc_last, pr_last, f_last, last_tile;
  logic [TW-1:0]    trow_d, tcol_d;
  logic [PCW-1:0]   pcol_d;
  logic [PRW-1:0]   prow_d;
  logic [FW-1:0]    feat_d;
  logic [DW-1:0]    max_d;

  function automatic logic [DW-1:0] pool_max(input logic [DW-1:0] held, input logic [DW-1:0] cand);
`ifdef POOL_SIGNED_EN
    return ($signed(cand) > $signed(held)) ? cand : held;
`else
    return (cand > held) ? cand : held;
`endif
  endfunction

  // Tile geometry clipped to the map so edge tiles only visit in-bounds elements
  always_comb begin
    tile_r0   = 32'(prow_q) * 32'(POOLING_STRIDE);
    tile_c0   = 32'(pcol_q) * 32'(POOLING_STRIDE);
    tile_h    = (32'(CONVOLUTION_HEIGHT) - tile_r0 < 32'(POOLING_STRIDE)) ?
                (32'(CONVOLUTION_HEIGHT) - tile_r0) : 32'(POOLING_STRIDE);
    tile_w    = (32'(CONVOLUTION_WIDTH) - tile_c0 < 32'(POOLING_STRIDE)) ?
                (32'(CONVOLUTION_WIDTH) - tile_c0) : 32'(POOLING_STRIDE);
    col_wrap  = (32'(tcol_q) + 32'd1 >= tile_w);
    row_end   = (32'(trow_q) + 32'd1 >= tile_h);
    last_elem = col_wrap && row_end;
    trow_d    = col_wrap ? trow_q + 1'b1 : trow_q;
    tcol_d    = col_wrap ? '0 : tcol_q + 1'b1;

    pc_last   = (pcol_q == PC_LAST);
    pr_last   = (prow_q == PR_LAST);
    f_last    = (feat_q == F_LAST);
    last_tile = pc_last && pr_last && f_last;
    pcol_d    = pc_last ? '0 : pcol_q + 1'b1;
    prow_d    = pc_last ? (pr_last ? '0 : prow_q + 1'b1) : prow_q;
    feat_d    = (pc_last && pr_last) ? feat_q + 1'b1 : feat_q;
    next_r0   = 32'(prow_d) * 32'(POOLING_STRIDE);
    next_c0   = 32'(pcol_d) * 32'(POOLING_STRIDE);

    max_d     = rd_vld_q ? pool_max(max_q, rd_data) : max_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      feat_q       <= '0;
      prow_q       <= '0;
      pcol_q       <= '0;
      trow_q       <= '0;
      tcol_q       <= '0;
      max_q        <= '0;
      rd_vld_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_valid_q   <= 1'b0;
      rd_feature_q <= '0;
      rd_row_q     <= '0;
      rd_col_q     <= '0;
      wr_feature_q <= '0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_data_q    <= '0;
    end else begin
      rd_vld_q <= rd_en_q;
      max_q    <= max_d;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pool_start) begin
            state_q      <= S_READ;
            busy_q       <= 1'b1;
            feat_q       <= '0;
            prow_q       <= '0;
            pcol_q       <= '0;
            trow_q       <= '0;
            tcol_q       <= '0;
            max_q        <= MAX_INIT;
            rd_en_q      <= 1'b1;
            rd_feature_q <= '0;
            rd_row_q     <= '0;
            rd_col_q     <= '0;
          end
        end
        S_READ: begin
          if (last_elem) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            trow_q   <= trow_d;
            tcol_q   <= tcol_d;
            rd_row_q <= RW'(tile_r0 + 32'(trow_d));
            rd_col_q <= CW'(tile_c0 + 32'(tcol_d));
          end
        end
        // Last read data lands this cycle; the folded max is what gets written
        S_DRAIN: begin
          state_q      <= S_WRITE;
          wr_valid_q   <= 1'b1;
          wr_feature_q <= feat_q;
          wr_row_q     <= prow_q;
          wr_col_q     <= pcol_q;
          wr_data_q    <= max_d;
        end
        S_WRITE: begin
          if (wr_ready) begin
            wr_valid_q <= 1'b0;
            if (last_tile) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= S_READ;
              feat_q       <= feat_d;
              prow_q       <= prow_d;
              pcol_q       <= pcol_d;
              trow_q       <= '0;
              tcol_q       <= '0;
              max_q        <= MAX_INIT;
              rd_en_q      <= 1'b1;
              rd_feature_q <= feat_d;
              rd_row_q     <= RW'(next_r0);
              rd_col_q     <= CW'(next_c0);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pool_busy  = busy_q;
  assign pool_done  = done_q;
  assign rd_en      = rd_en_q;
  assign rd_feature = rd_feature_q;
  assign rd_row     = rd_row_q;
  assign rd_col     = rd_col_q;
  assign wr_valid   = wr_valid_q;
  assign wr_feature = wr_feature_q;
  assign wr_row     = wr_row_q;
  assign wr_col     = wr_col_q;
  assign wr_data    = wr_data_q;

endmodule
